// File: rtl/led_cnt_cfg_seq.sv
// led_cnt_cfg_seq: steps the LED counter divider, applies host overrides
// and sequences the partial-reconfiguration decouple/ack handshake.
module led_cnt_cfg_seq #(
  parameter int DIV_MIN     = 4,
  parameter int DIV_MAX     = 24,
  parameter int DWELL       = 1000,
  parameter int DWELL_W     = 32,
  parameter int RECOVER_CYC = 16
) (
  input  logic       clk100,
  input  logic       rstn,
  input  logic       en_i,
  input  logic       cfg_load_i,
  input  logic [4:0] cfg_div_i,
  output logic       load_ack_o,
  input  logic       pr_req_i,
  input  logic       pr_done_i,
  output logic       decouple_o,
  output logic       pr_ack_o,
  output logic [4:0] div_o,
  output logic       wren_o,
  output logic       busy_o
);

  localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  localparam logic [4:0] MIN_V = 5'(DIV_MIN);
  localparam logic [4:0] MAX_V = 5'(DIV_MAX);

  localparam logic [DWELL_W-1:0] DW_LD = DWELL_W'(DWELL - 1);
  localparam logic [RC_W-1:0]    RC_LD = RC_W'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_DWELL,
    S_DECOUPLE,
    S_PR_WAIT,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         div_q, div_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic               ld_q, ld_d;
  logic               lack_q, lack_d;
  logic               wren_q, wren_d;
  logic               dec_q, dec_d;
  logic               prack_q, prack_d;
  logic               busy_q, busy_d;

  function automatic logic [4:0] clamp(input logic [4:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic logic [4:0] step(input logic [4:0] v);
    return (v == MAX_V) ? MIN_V : v + 5'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    ld_d    = 1'b0;
    lack_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DWELL: begin
        if (pr_req_i) begin
          state_d = S_DECOUPLE;
        end else if (cfg_load_i) begin
          div_d   = clamp(cfg_div_i);
          lack_d  = 1'b1;
          ld_d    = 1'b1;
          state_d = S_WRITE;
        end else if (state_q == S_IDLE) begin
          if (en_i) state_d = S_WRITE;
        end else if (cnt_q == '0) begin
          div_d   = step(div_q);
          state_d = en_i ? S_WRITE : S_IDLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      // after a load, WRITE spends one settle cycle before the strobe
      S_WRITE: begin
        if (!ld_q) begin
          state_d = S_DWELL;
          cnt_d   = DW_LD;
        end
      end
      S_DECOUPLE: state_d = S_PR_WAIT;
      S_PR_WAIT: begin
        if (pr_done_i) begin
          state_d = S_RECOVER;
          rc_d    = RC_LD;
        end
      end
      S_RECOVER: begin
        if (rc_q == '0) state_d = S_WRITE;
        else rc_d = rc_q - RC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wren_d  = (state_d == S_WRITE) && !ld_d;
    dec_d   = state_d inside {S_DECOUPLE, S_PR_WAIT, S_RECOVER};
    prack_d = (state_d == S_PR_WAIT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= MIN_V;
      cnt_q   <= '0;
      rc_q    <= '0;
      ld_q    <= 1'b0;
      lack_q  <= 1'b0;
      wren_q  <= 1'b0;
      dec_q   <= 1'b0;
      prack_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      ld_q    <= ld_d;
      lack_q  <= lack_d;
      wren_q  <= wren_d;
      dec_q   <= dec_d;
      prack_q <= prack_d;
      busy_q  <= busy_d;
    end
  end

  assign div_o      = div_q;
  assign wren_o     = wren_q;
  assign load_ack_o = lack_q;
  assign decouple_o = dec_q;
  assign pr_ack_o   = prack_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_led_cnt_cfg_seq.sv
// Self-checking bench for led_cnt_cfg_seq: directed scenarios plus
// randomized stimulus against a behavioural reference model.
module tb_led_cnt_cfg_seq;

  localparam int DMIN = 22;
  localparam int DMAX = 24;
  localparam int DW   = 4;
  localparam int RC   = 16;

  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       en_i = 1'b0;
  logic       cfg_load_i = 1'b0;
  logic [4:0] cfg_div_i = 5'd0;
  logic       pr_req_i = 1'b0;
  logic       pr_done_i = 1'b0;
  logic       load_ack_o;
  logic       decouple_o;
  logic       pr_ack_o;
  logic [4:0] div_o;
  logic       wren_o;
  logic       busy_o;

  int n_chk = 0;
  int n_fail = 0;

  led_cnt_cfg_seq #(
    .DIV_MIN(DMIN),
    .DIV_MAX(DMAX),
    .DWELL(DW),
    .DWELL_W(8),
    .RECOVER_CYC(RC)
  ) dut (
    .clk100(clk100),
    .rstn(rstn),
    .en_i(en_i),
    .cfg_load_i(cfg_load_i),
    .cfg_div_i(cfg_div_i),
    .load_ack_o(load_ack_o),
    .pr_req_i(pr_req_i),
    .pr_done_i(pr_done_i),
    .decouple_o(decouple_o),
    .pr_ack_o(pr_ack_o),
    .div_o(div_o),
    .wren_o(wren_o),
    .busy_o(busy_o)
  );

  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic test_reset();
    int wr;
    int bz;
    rstn = 1'b0;
    repeat (2) tick();
    n_chk++;
    if ({div_o, wren_o, decouple_o, pr_ack_o, load_ack_o, busy_o}
        !== {5'd22, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_vals: div=%0d wr=%b dec=%b ack=%b lack=%b busy=%b, want div=22 rest 0",
               div_o, wren_o, decouple_o, pr_ack_o, load_ack_o, busy_o);
    end
    rstn = 1'b1;
    wr = 0;
    bz = 0;
    repeat (100) begin
      tick();
      if (wren_o) wr++;
      if (busy_o) bz++;
    end
    n_chk++;
    if (wr != 0 || bz != 0) begin
      n_fail++;
      $display("FAIL reset_idle: wren count %0d busy count %0d, want 0 0", wr, bz);
    end
  endtask

  task automatic test_free_run();
    int k;
    int wr;
    int want;
    k = 0;
    en_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (wren_o) begin
        want = DMIN + (k % (DMAX - DMIN + 1));
        n_chk++;
        if (i != k * (DW + 1) || div_o !== 5'(want)) begin
          n_fail++;
          $display("FAIL free_run_strobe%0d: cycle %0d div %0d, want cycle %0d div %0d",
                   k, i, div_o, k * (DW + 1), want);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL free_run_count: %0d strobes, want 5", k);
    end
    en_i = 1'b0;
    wr = 0;
    repeat (20) begin
      tick();
      if (wren_o) wr++;
    end
    n_chk++;
    if (wr != 0 || busy_o !== 1'b0 || div_o !== 5'd24) begin
      n_fail++;
      $display("FAIL free_run_stop: wr %0d busy %b div %0d, want 0 0 24", wr, busy_o, div_o);
    end
  endtask

  task automatic test_load();
    int wr;
    cfg_div_i = 5'd31;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    n_chk++;
    if (load_ack_o !== 1'b1 || div_o !== 5'd24 || wren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_hi_ack: lack %b div %0d wr %b, want 1 24 0", load_ack_o, div_o, wren_o);
    end
    tick();
    n_chk++;
    if (wren_o !== 1'b1 || div_o !== 5'd24 || load_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_hi_wr: wr %b div %0d lack %b, want 1 24 0", wren_o, div_o, load_ack_o);
    end
    tick();
    cfg_div_i = 5'd2;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    n_chk++;
    if (load_ack_o !== 1'b1 || div_o !== 5'd22 || wren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_lo_ack: lack %b div %0d wr %b, want 1 22 0", load_ack_o, div_o, wren_o);
    end
    en_i = 1'b1;
    tick();
    n_chk++;
    if (wren_o !== 1'b1 || div_o !== 5'd22) begin
      n_fail++;
      $display("FAIL load_lo_wr: wr %b div %0d, want 1 22", wren_o, div_o);
    end
    wr = 0;
    repeat (DW) begin
      tick();
      if (wren_o) wr++;
    end
    tick();
    n_chk++;
    if (wr != 0 || wren_o !== 1'b1 || div_o !== 5'd23) begin
      n_fail++;
      $display("FAIL load_step: early %0d wr %b div %0d, want 0 1 23", wr, wren_o, div_o);
    end
    en_i = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_pr();
    int bad;
    cfg_div_i = 5'd23;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    tick();
    tick();
    tick();
    pr_req_i = 1'b1;
    tick();
    pr_req_i = 1'b0;
    n_chk++;
    if (decouple_o !== 1'b1 || pr_ack_o !== 1'b0 || wren_o !== 1'b0 || div_o !== 5'd23) begin
      n_fail++;
      $display("FAIL pr_decouple: dec %b ack %b wr %b div %0d, want 1 0 0 23",
               decouple_o, pr_ack_o, wren_o, div_o);
    end
    tick();
    n_chk++;
    if (decouple_o !== 1'b1 || pr_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pr_ack: dec %b ack %b, want 1 1", decouple_o, pr_ack_o);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (wren_o || !pr_ack_o || !decouple_o) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pr_hold: %0d bad cycles, want 0", bad);
    end
    pr_done_i = 1'b1;
    tick();
    pr_done_i = 1'b0;
    n_chk++;
    if (pr_ack_o !== 1'b0 || decouple_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pr_done: ack %b dec %b, want 0 1", pr_ack_o, decouple_o);
    end
    bad = 0;
    repeat (RC - 1) begin
      tick();
      if (!decouple_o || wren_o) bad++;
    end
    tick();
    n_chk++;
    if (bad != 0 || decouple_o !== 1'b0 || wren_o !== 1'b1 || div_o !== 5'd23) begin
      n_fail++;
      $display("FAIL pr_replay: bad %0d dec %b wr %b div %0d, want 0 0 1 23",
               bad, decouple_o, wren_o, div_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_collide();
    cfg_div_i = 5'd22;
    cfg_load_i = 1'b1;
    pr_req_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    pr_req_i = 1'b0;
    n_chk++;
    if (decouple_o !== 1'b1 || load_ack_o !== 1'b0 || div_o !== 5'd24) begin
      n_fail++;
      $display("FAIL coll_req_load: dec %b lack %b div %0d, want 1 0 24",
               decouple_o, load_ack_o, div_o);
    end
    tick();
    cfg_load_i = 1'b1;
    pr_done_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    pr_done_i = 1'b0;
    n_chk++;
    if (load_ack_o !== 1'b0 || div_o !== 5'd24 || pr_ack_o !== 1'b0 || decouple_o !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_load_done: lack %b div %0d ack %b dec %b, want 0 24 0 1",
               load_ack_o, div_o, pr_ack_o, decouple_o);
    end
    repeat (RC) tick();
    n_chk++;
    if (wren_o !== 1'b1 || decouple_o !== 1'b0 || div_o !== 5'd24) begin
      n_fail++;
      $display("FAIL coll_replay: wr %b dec %b div %0d, want 1 0 24", wren_o, decouple_o, div_o);
    end
    repeat (DW + 1) tick();
    n_chk++;
    if (busy_o !== 1'b0 || div_o !== 5'd22) begin
      n_fail++;
      $display("FAIL coll_wrap: busy %b div %0d, want 0 22", busy_o, div_o);
    end
  endtask

  task automatic test_reset_mid_pr();
    int bad;
    cfg_div_i = 5'd23;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    tick();
    tick();
    pr_req_i = 1'b1;
    tick();
    pr_req_i = 1'b0;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({decouple_o, pr_ack_o, wren_o, busy_o} !== 4'b0000 || div_o !== 5'd22) begin
      n_fail++;
      $display("FAIL reset_mid_pr: dec %b ack %b wr %b busy %b div %0d, want 0 0 0 0 22",
               decouple_o, pr_ack_o, wren_o, busy_o, div_o);
    end
    #1;
    rstn = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (wren_o || busy_o || decouple_o || div_o !== 5'd22) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_restart: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_random();
    int  m_div;
    int  m_dwell;
    int  m_rec;
    bit  m_wn;
    bit  m_wnext;
    bit  m_dec1;
    bit  m_wait;
    bit  idle;
    bit  open;
    bit  e_lack;
    int  shown;
    int  overlap;
    int  v;
    logic [9:0] got;
    logic [9:0] want;
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    m_div = DMIN;
    m_dwell = -1;
    m_rec = 0;
    m_wn = 0;
    m_wnext = 0;
    m_dec1 = 0;
    m_wait = 0;
    shown = 0;
    overlap = 0;
    for (int c = 0; c < 3000; c++) begin
      en_i       = ($urandom_range(0, 9) < 7);
      cfg_load_i = ($urandom_range(0, 19) == 0);
      pr_req_i   = ($urandom_range(0, 39) == 0);
      pr_done_i  = ($urandom_range(0, 7) == 0);
      cfg_div_i  = 5'($urandom_range(0, 31));
      tick();
      idle = !(m_wn || m_wnext || m_dec1 || m_wait) && m_dwell < 0 && m_rec == 0;
      open = idle || m_dwell >= 0;
      e_lack = 0;
      if (open && pr_req_i) begin
        m_dwell = -1;
        m_dec1 = 1;
      end else if (open && cfg_load_i) begin
        v = int'(cfg_div_i);
        if (v < DMIN) v = DMIN;
        if (v > DMAX) v = DMAX;
        m_div = v;
        m_dwell = -1;
        e_lack = 1;
        m_wnext = 1;
      end else if (m_dwell > 0) begin
        m_dwell--;
      end else if (m_dwell == 0) begin
        m_dwell = -1;
        m_div = (m_div == DMAX) ? DMIN : m_div + 1;
        m_wn = en_i;
      end else if (idle) begin
        m_wn = en_i;
      end else if (m_wnext) begin
        m_wnext = 0;
        m_wn = 1;
      end else if (m_wn) begin
        m_wn = 0;
        m_dwell = DW - 1;
      end else if (m_dec1) begin
        m_dec1 = 0;
        m_wait = 1;
      end else if (m_wait) begin
        if (pr_done_i) begin
          m_wait = 0;
          m_rec = RC;
        end
      end else if (m_rec > 1) begin
        m_rec--;
      end else begin
        m_rec = 0;
        m_wn = 1;
      end
      want = {5'(m_div), m_wn, (m_dec1 || m_wait || m_rec > 0), m_wait, e_lack,
              (m_wn || m_wnext || m_dec1 || m_wait || m_dwell >= 0 || m_rec > 0)};
      got = {div_o, wren_o, decouple_o, pr_ack_o, load_ack_o, busy_o};
      if (wren_o && decouple_o) overlap++;
      n_chk++;
      if (got !== want) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_c%0d: {div,wr,dec,ack,lack,busy} got %b want %b", c, got, want);
        end
      end
    end
    en_i = 1'b0;
    cfg_load_i = 1'b0;
    pr_req_i = 1'b0;
    pr_done_i = 1'b0;
    n_chk++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL random_wren_decouple: %0d overlapping cycles, want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_pr();
    test_collide();
    test_reset_mid_pr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
